// File: rtl/mips_data_port_pkg.sv
// Shared definitions for the MIPS data-side port: I/O address map, STATUS layout, decode select.
package mips_data_port_pkg;

  localparam logic [31:0] IoBase     = 32'hFFFF_FF00;
  localparam logic [31:0] AddrGpio   = 32'hFFFF_FF00;
  localparam logic [31:0] AddrTimer  = 32'hFFFF_FF04;
  localparam logic [31:0] AddrTxData = 32'hFFFF_FF08;
  localparam logic [31:0] AddrStatus = 32'hFFFF_FF0C;

  localparam int unsigned StatusOvfBit   = 16;
  localparam int unsigned StatusFullBit  = 9;
  localparam int unsigned StatusEmptyBit = 8;
  localparam int unsigned StatusClrBit   = 0;

  typedef enum logic [2:0] {
    SelNone,
    SelRam,
    SelGpio,
    SelTimer,
    SelTxData,
    SelStatus
  } sel_e;

  // Builds the 32-bit STATUS word; count must already be zero-extended to 8 bits.
  function automatic logic [31:0] status_word(input logic       ovf,
                                              input logic       full,
                                              input logic       empty,
                                              input logic [7:0] count);
    logic [31:0] w;
    w                 = '0;
    w[7:0]            = count;
    w[StatusEmptyBit] = empty;
    w[StatusFullBit]  = full;
    w[StatusOvfBit]   = ovf;
    return w;
  endfunction

endpackage

// File: rtl/mips_data_port_tx_fifo.sv
// Byte-wide TX FIFO; a push on a full FIFO is accepted only if a pop frees a slot the same cycle.
module mips_data_port_tx_fifo #(
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic [7:0]      din_i,
  input  logic            pop_i,
  output logic [7:0]      dout_o,
  output logic            empty_o,
  output logic            full_o,
  output logic [CntW-1:0] count_o,
  output logic            drop_o
);

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;

  // Pop on empty is ignored so a stray ready cannot corrupt the pointers.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & full_o & ~do_pop;

  // No same-cycle bypass: head shows zero while empty.
  assign dout_o = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    count_d = count_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/mips_data_port.sv
// Memory-stage data slave: local RAM plus GPIO, timer and TX FIFO registers; never stalls the core.
module mips_data_port
  import mips_data_port_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RAM_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              we_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [DATA_W-1:0] gpio_out_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i
);

  localparam int unsigned RamAw = $clog2(RAM_WORDS);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;

  sel_e              sel;
  logic [DATA_W-1:0] word_addr;
  logic [RamAw-1:0]  ram_idx;
  logic [DATA_W-1:0] ram_q [RAM_WORDS];
  logic [DATA_W-1:0] gpio_q, gpio_d;
  logic [DATA_W-1:0] timer_q, timer_d;
  logic              ovf_q, ovf_d;
  logic              ram_we, push, ovf_clr;
  logic              fifo_empty, fifo_full, fifo_drop;
  logic [CntW-1:0]   fifo_count;
  logic [31:0]       status;
  logic              unused_addr;

  // Byte offset is ignored: word accesses only.
  assign unused_addr = ^addr_i[1:0];
  assign word_addr   = {addr_i[DATA_W-1:2], 2'b00};
  assign ram_idx     = addr_i[RamAw+1:2];

  always_comb begin
    sel = SelNone;
    if (addr_i[DATA_W-1:RamAw+2] == '0) begin
      sel = SelRam;
    end else if (word_addr == DATA_W'(AddrGpio)) begin
      sel = SelGpio;
    end else if (word_addr == DATA_W'(AddrTimer)) begin
      sel = SelTimer;
    end else if (word_addr == DATA_W'(AddrTxData)) begin
      sel = SelTxData;
    end else if (word_addr == DATA_W'(AddrStatus)) begin
      sel = SelStatus;
    end
  end

  assign ram_we  = we_i & (sel == SelRam);
  assign push    = we_i & (sel == SelTxData);
  assign ovf_clr = we_i & (sel == SelStatus) & wdata_i[StatusClrBit];

  always_comb begin
    gpio_d  = gpio_q;
    timer_d = timer_q + DATA_W'(1);
    ovf_d   = ovf_q;
    if (we_i && sel == SelGpio) begin
      gpio_d = wdata_i;
    end
    if (we_i && sel == SelTimer) begin
      timer_d = wdata_i;
    end
    // A drop in the same cycle as a clear leaves overflow set.
    if (fifo_drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_q  <= '0;
      timer_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      gpio_q  <= gpio_d;
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_idx] <= wdata_i;
    end
  end

  mips_data_port_tx_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .din_i  (wdata_i[7:0]),
    .pop_i  (tx_ready_i),
    .dout_o (tx_data_o),
    .empty_o(fifo_empty),
    .full_o (fifo_full),
    .count_o(fifo_count),
    .drop_o (fifo_drop)
  );

  assign tx_valid_o = ~fifo_empty;
  assign gpio_out_o = gpio_q;
  assign status     = status_word(ovf_q, fifo_full, fifo_empty, 8'(fifo_count));

  always_comb begin
    rdata_o = '0;
    unique case (sel)
      SelRam:    rdata_o = ram_q[ram_idx];
      SelGpio:   rdata_o = gpio_q;
      SelTimer:  rdata_o = timer_q;
      SelTxData: rdata_o = '0;
      SelStatus: rdata_o = DATA_W'(status);
      default:   rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_mips_data_port.sv
// Directed bench for mips_data_port: reset, RAM, timer, TX FIFO, GPIO and unmapped accesses.
module tb_mips_data_port;

  localparam logic [31:0] AGpio   = 32'hFFFF_FF00;
  localparam logic [31:0] ATimer  = 32'hFFFF_FF04;
  localparam logic [31:0] ATxData = 32'hFFFF_FF08;
  localparam logic [31:0] AStatus = 32'hFFFF_FF0C;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic [31:0] gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int unsigned n_checks;
  int unsigned n_fail;

  mips_data_port #(
    .DATA_W    (32),
    .RAM_WORDS (256),
    .FIFO_DEPTH(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .we_i      (we),
    .rdata_o   (rdata),
    .gpio_out_o(gpio_out),
    .tx_data_o (tx_data),
    .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    we   = 1'b0;
    #1;
    d = rdata;
  endtask

  logic [31:0] v;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    addr     = '0;
    wdata    = '0;
    we       = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_gpio", gpio_out, 32'h0);
    check_eq("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check_eq("rst_tx_data", {24'b0, tx_data}, 32'h0);

    rst_n = 1'b1;
    rd(ATimer, v);
    check_eq("timer_0", v, 32'h0);
    step();
    check_eq("timer_1", rdata, 32'h1);
    step();
    check_eq("timer_2", rdata, 32'h2);
    rd(AStatus, v);
    check_eq("status_reset", v, 32'h0000_0100);

    // RAM: store then load, and same-cycle load returns the old word
    wr(32'h10, 32'h1111_1111);
    addr  = 32'h10;
    wdata = 32'hDEAD_BEEF;
    we    = 1'b1;
    #1;
    check_eq("ram_same_cycle", rdata, 32'h1111_1111);
    step();
    we = 1'b0;
    rd(32'h10, v);
    check_eq("ram_load", v, 32'hDEAD_BEEF);
    wr(32'h14, 32'h0BAD_F00D);
    rd(32'h10, v);
    check_eq("ram_neighbour", v, 32'hDEAD_BEEF);
    rd(32'h17, v);
    check_eq("ram_byte_ofs", v, 32'h0BAD_F00D);

    // Timer load and wrap
    wr(ATimer, 32'hFFFF_FFFE);
    #1;
    check_eq("timer_load", rdata, 32'hFFFF_FFFE);
    step();
    check_eq("timer_max", rdata, 32'hFFFF_FFFF);
    step();
    check_eq("timer_wrap", rdata, 32'h0);

    // GPIO: output changes only after the edge
    addr  = AGpio;
    wdata = 32'hA5;
    we    = 1'b1;
    #1;
    check_eq("gpio_pre_edge", gpio_out, 32'h0);
    step();
    we = 1'b0;
    check_eq("gpio_out", gpio_out, 32'hA5);
    rd(AGpio, v);
    check_eq("gpio_read", v, 32'hA5);

    // Unmapped store has no effect
    wr(32'h8000_0000, 32'h1234);
    rd(32'h8000_0000, v);
    check_eq("unmapped_read", v, 32'h0);
    check_eq("unmapped_gpio", gpio_out, 32'hA5);
    rd(AStatus, v);
    check_eq("unmapped_status", v, 32'h0000_0100);
    rd(32'h10, v);
    check_eq("unmapped_ram", v, 32'hDEAD_BEEF);
    rd(ATxData, v);
    check_eq("txdata_read", v, 32'h0);

    // FIFO fill past depth: ninth byte dropped, overflow sets
    tx_ready = 1'b0;
    addr  = ATxData;
    wdata = 32'h41;
    we    = 1'b1;
    #1;
    check_eq("no_bypass", {31'b0, tx_valid}, 32'h0);
    step();
    we = 1'b0;
    check_eq("first_valid", {31'b0, tx_valid}, 32'h1);
    check_eq("first_head", {24'b0, tx_data}, 32'h41);
    for (int i = 1; i < 9; i++) begin
      wr(ATxData, 32'h41 + i);
    end
    rd(AStatus, v);
    check_eq("status_full_ovf", v, 32'h0001_0208);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq($sformatf("drain_%0d", i), {23'b0, tx_valid, tx_data}, 32'h100 + 32'h41 + i);
      step();
    end
    check_eq("drained_valid", {31'b0, tx_valid}, 32'h0);
    step();
    rd(AStatus, v);
    check_eq("status_drained", v, 32'h0001_0100);
    wr(AStatus, 32'h1);
    rd(AStatus, v);
    check_eq("ovf_clear", v, 32'h0000_0100);

    // Full + push + pop in one cycle
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr(ATxData, 32'h50 + i);
    end
    rd(AStatus, v);
    check_eq("status_full", v, 32'h0000_0208);
    addr     = ATxData;
    wdata    = 32'h58;
    we       = 1'b1;
    tx_ready = 1'b1;
    step();
    we       = 1'b0;
    tx_ready = 1'b0;
    rd(AStatus, v);
    check_eq("full_push_pop", v, 32'h0000_0208);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq($sformatf("fpp_drain_%0d", i), {23'b0, tx_valid, tx_data}, 32'h100 + 32'h51 + i);
      step();
    end
    check_eq("fpp_empty", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // Reset mid-run with GPIO set, FIFO loaded and overflow set
    for (int i = 0; i < 9; i++) begin
      wr(ATxData, 32'h60 + i);
    end
    wr(ATimer, 32'h0000_1000);
    rd(AStatus, v);
    check_eq("pre_reset_status", v, 32'h0001_0208);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_gpio", gpio_out, 32'h0);
    check_eq("mid_rst_valid", {31'b0, tx_valid}, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    rd(ATimer, v);
    check_eq("mid_rst_timer_0", v, 32'h0);
    step();
    check_eq("mid_rst_timer_1", rdata, 32'h1);
    step();
    check_eq("mid_rst_timer_2", rdata, 32'h2);
    rd(AStatus, v);
    check_eq("mid_rst_status", v, 32'h0000_0100);
    check_eq("mid_rst_tx_data", {24'b0, tx_data}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
